// File: rtl/stage0_ctrl_if.sv
// Handshake and strobe bundle between stage0_ctrl, the parameter/pixel sources and the stage0 datapath.
interface stage0_ctrl_if #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
);
  logic                     param_valid;
  logic                     param_ready;
  logic                     pix_valid;
  logic                     pix_ready;
  logic                     weight_en;
  logic                     weight_mode;
  logic                     pix_en;
  logic [$clog2(IMG_H)-1:0] row;
  logic [$clog2(IMG_W)-1:0] col;
  logic                     out_valid;

  modport master (
    output param_valid, pix_valid,
    input  param_ready, pix_ready, weight_en, weight_mode, pix_en, row, col, out_valid
  );

  modport slave (
    input  param_valid, pix_valid,
    output param_ready, pix_ready, weight_en, weight_mode, pix_en, row, col, out_valid
  );
endinterface

// File: rtl/stage0_ctrl.sv
// Layer sequencer for stage0: shifts DW weights then BN config into the parameter chain,
// then streams one frame with row/col tracking and a latency-aligned output-valid flag.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_LOAD_W  | shifting W_WORDS weight words (weight_mode=0)
// S_LOAD_BN | shifting BN_WORDS BN config words (weight_mode=1)
// S_RUN     | accepting frame pixels
// S_DRAIN   | letting the last tags leave the PIPE_LAT pipe
// S_DONE    | one-cycle done pulse
module stage0_ctrl #(
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int W_WORDS  = 9,
  parameter int BN_WORDS = 9,
  parameter int PIPE_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          cfg_relu,
  input  logic          cfg_skip,
  stage0_ctrl_if.slave  bus,
  output logic          relu_sel,
  output logic          skip_stage0,
  output logic          busy,
  output logic          done
);
  localparam int RW   = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);
  localparam int WMAX = (W_WORDS > BN_WORDS) ? W_WORDS : BN_WORDS;
  localparam int WCW  = $clog2(WMAX + 1);
  localparam int DW   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_BN, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t              state, nxt;
  logic [WCW-1:0]      wcnt;
  logic [RW-1:0]       row_q;
  logic [CW-1:0]       col_q;
  logic [DW-1:0]       dcnt;
  logic [PIPE_LAT-1:0] vpipe;
  logic                relu_q, skip_q, mode_q;

  logic param_ready_c, pix_ready_c, weight_en_c, weight_mode_c, pix_en_c;
  logic out_valid_c, busy_c, done_c;
  logic last_word, last_row, last_col, tag;

  assign last_word = (state == S_LOAD_BN) ? (wcnt == WCW'(BN_WORDS - 1))
                                          : (wcnt == WCW'(W_WORDS - 1));
  assign last_row  = (row_q == RW'(IMG_H - 1));
  assign last_col  = (col_q == CW'(IMG_W - 1));
  // Only pixels with a full 3x3 neighbourhood produce an output in conv mode.
  assign tag       = pix_en_c & ~skip_q & (row_q >= RW'(2)) & (col_q >= CW'(2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start) nxt = cfg_skip ? S_RUN : S_LOAD_W;
        S_LOAD_W:  if (weight_en_c && last_word) nxt = S_LOAD_BN;
        S_LOAD_BN: if (weight_en_c && last_word) nxt = S_RUN;
        S_RUN:     if (pix_en_c && last_row && last_col) nxt = skip_q ? S_DONE : S_DRAIN;
        S_DRAIN:   if (dcnt == '0) nxt = S_DONE;
        S_DONE:    nxt = S_IDLE;
        default:   nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    param_ready_c = 1'b0;
    pix_ready_c   = 1'b0;
    weight_mode_c = mode_q;
    busy_c        = (state != S_IDLE);
    done_c        = (state == S_DONE);
    case (state)
      S_LOAD_W:  begin param_ready_c = 1'b1; weight_mode_c = 1'b0; end
      S_LOAD_BN: begin param_ready_c = 1'b1; weight_mode_c = 1'b1; end
      S_RUN:     pix_ready_c = 1'b1;
      default:   ;
    endcase
    weight_en_c = bus.param_valid & param_ready_c & ~abort;
    pix_en_c    = bus.pix_valid & pix_ready_c;
    out_valid_c = skip_q ? pix_en_c : vpipe[PIPE_LAT-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt   <= '0;
      row_q  <= '0;
      col_q  <= '0;
      dcnt   <= '0;
      vpipe  <= '0;
      relu_q <= 1'b0;
      skip_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      mode_q <= weight_mode_c;
      if (abort) begin
        wcnt  <= '0;
        row_q <= '0;
        col_q <= '0;
        dcnt  <= '0;
        vpipe <= '0;
      end else begin
        vpipe <= PIPE_LAT'({vpipe, tag});
        if (state == S_IDLE && start) begin
          relu_q <= cfg_relu;
          skip_q <= cfg_skip;
        end
        if (weight_en_c) wcnt <= last_word ? '0 : wcnt + WCW'(1);
        if (pix_en_c) begin
          if (last_col) begin
            col_q <= '0;
            row_q <= last_row ? '0 : row_q + RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        // Drain timer is preloaded while running and counts down to its terminal zero.
        if (state == S_RUN)                        dcnt <= DW'(PIPE_LAT - 1);
        else if (state == S_DRAIN && dcnt != '0)   dcnt <= dcnt - DW'(1);
      end
    end
  end

  assign bus.param_ready = param_ready_c;
  assign bus.pix_ready   = pix_ready_c;
  assign bus.weight_en   = weight_en_c;
  assign bus.weight_mode = weight_mode_c;
  assign bus.pix_en      = pix_en_c;
  assign bus.row         = row_q;
  assign bus.col         = col_q;
  assign bus.out_valid   = out_valid_c;
  assign relu_sel        = relu_q;
  assign skip_stage0     = skip_q;
  assign busy            = busy_c;
  assign done            = done_c;
endmodule

// File: tb/tb_stage0_ctrl.sv
// Randomized bench for stage0_ctrl: a procedural layer model predicts every output per cycle.
module tb_stage0_ctrl;
  localparam int IMG_W    = 4;
  localparam int IMG_H    = 4;
  localparam int W_WORDS  = 9;
  localparam int BN_WORDS = 9;
  localparam int PIPE_LAT = 2;
  localparam int NPIX     = IMG_W * IMG_H;

  logic clk, reset, start, abort, cfg_relu, cfg_skip;
  logic relu_sel, skip_stage0, busy, done;

  stage0_ctrl_if #(.IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

  stage0_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .W_WORDS(W_WORDS), .BN_WORDS(BN_WORDS), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_relu(cfg_relu), .cfg_skip(cfg_skip), .bus(bus),
    .relu_sel(relu_sel), .skip_stage0(skip_stage0), .busy(busy), .done(done)
  );

  int n_tests, n_fail, cyc;
  bit ov_sched [0:8191];
  bit exp_relu, exp_skip, exp_mode;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic bit pick(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      2:       return (k % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic noise();
    start    = 1'($urandom);
    cfg_relu = 1'($urandom);
    cfg_skip = 1'($urandom);
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_relu"}, relu_sel, exp_relu);
    chk({tag, "_skip"}, skip_stage0, exp_skip);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_param_ready"}, bus.param_ready, 0);
    chk({tag, "_pix_ready"}, bus.pix_ready, 0);
    chk({tag, "_wen"}, bus.weight_en, 0);
    chk({tag, "_ov"}, bus.out_valid, 0);
    chk({tag, "_row"}, bus.row, 0);
    chk({tag, "_col"}, bus.col, 0);
    chk({tag, "_mode"}, bus.weight_mode, exp_mode);
    chk_hold(tag);
  endtask

  // kill: 0 none, 1 abort at BN word 4, 2 abort on last pixel, 3 reset after 5 pixels
  task automatic run_layer(input bit skip, input bit relu, input int pv_mode, input int xv_mode,
                           input int kill);
    int words, n, guard, acc;
    bit pv, xv;
    abort = 1'b0; start = 1'b1; cfg_relu = relu; cfg_skip = skip;
    bus.param_valid = 1'b0; bus.pix_valid = 1'b0;
    #1;
    chk_idle("start");
    step();
    exp_relu = relu; exp_skip = skip;

    if (!skip) begin
      for (int m = 0; m < 2; m++) begin
        n = (m == 0) ? W_WORDS : BN_WORDS;
        words = 0; guard = 0;
        while (words < n) begin
          pv = pick(pv_mode, guard);
          bus.param_valid = pv; bus.pix_valid = 1'($urandom); noise();
          abort = (kill == 1 && m == 1 && words == 4);
          exp_mode = m[0];
          #1;
          chk("ld_ready", bus.param_ready, 1);
          chk("ld_mode", bus.weight_mode, m);
          chk("ld_wen", bus.weight_en, pv && !abort);
          chk("ld_pix_ready", bus.pix_ready, 0);
          chk("ld_pix_en", bus.pix_en, 0);
          chk("ld_busy", busy, 1);
          chk("ld_done", done, 0);
          chk("ld_ov", bus.out_valid, 0);
          chk_hold("ld");
          step();
          if (abort) begin
            abort = 1'b0; start = 1'b0; bus.param_valid = 1'b0; bus.pix_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin #1; chk_idle("post_abort_ld"); step(); end
            return;
          end
          if (pv) words++;
          guard++;
          if (guard > 200) begin chk("ld_timeout", words, n); return; end
        end
      end
    end

    acc = 0; guard = 0;
    while (acc < NPIX) begin
      xv = pick(xv_mode, guard);
      bus.param_valid = 1'($urandom); bus.pix_valid = xv; noise();
      abort = (kill == 2 && xv && acc == NPIX - 1);
      if (kill == 3 && acc == 5) begin
        bus.pix_valid = 1'b1; reset = 1'b0;
        #1;
        exp_relu = 1'b0; exp_skip = 1'b0; exp_mode = 1'b0;
        chk_idle("in_reset");
        chk("in_reset_pix_en", bus.pix_en, 0);
        for (int k = 0; k <= PIPE_LAT; k++) ov_sched[cyc + k] = 1'b0;
        step();
        bus.pix_valid = 1'b0; start = 1'b0; reset = 1'b1;
        #1;
        chk_idle("after_reset");
        step();
        return;
      end
      #1;
      chk("run_pix_ready", bus.pix_ready, 1);
      chk("run_pix_en", bus.pix_en, xv);
      chk("run_wen", bus.weight_en, 0);
      chk("run_param_ready", bus.param_ready, 0);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_mode", bus.weight_mode, exp_mode);
      chk("run_row", bus.row, acc / IMG_W);
      chk("run_col", bus.col, acc % IMG_W);
      chk_hold("run");
      if (xv) begin
        if (skip) ov_sched[cyc] = 1'b1;
        else if (acc / IMG_W >= 2 && acc % IMG_W >= 2) ov_sched[cyc + PIPE_LAT] = 1'b1;
      end
      chk("run_ov", bus.out_valid, ov_sched[cyc]);
      step();
      if (xv) acc++;
      if (abort) begin
        abort = 1'b0; start = 1'b0; bus.pix_valid = 1'b0; bus.param_valid = 1'b0;
        for (int k = 0; k <= PIPE_LAT; k++) ov_sched[cyc + k] = 1'b0;
        for (int k = 0; k < 4; k++) begin #1; chk_idle("post_abort_run"); step(); end
        return;
      end
      guard++;
      if (guard > 300) begin chk("run_timeout", acc, NPIX); return; end
    end

    bus.param_valid = 1'b0;
    for (int k = 0; k < (skip ? 0 : PIPE_LAT); k++) begin
      bus.pix_valid = 1'($urandom); noise();
      #1;
      chk("drain_pix_ready", bus.pix_ready, 0);
      chk("drain_pix_en", bus.pix_en, 0);
      chk("drain_busy", busy, 1);
      chk("drain_done", done, 0);
      chk("drain_wen", bus.weight_en, 0);
      chk("drain_ov", bus.out_valid, ov_sched[cyc]);
      chk_hold("drain");
      step();
    end
    bus.pix_valid = 1'($urandom); noise();
    #1;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_pix_en", bus.pix_en, 0);
    chk("done_ov", bus.out_valid, ov_sched[cyc]);
    chk_hold("done");
    step();
    start = 1'b0; bus.pix_valid = 1'b0;
    #1;
    chk_idle("end");
    step();
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; cfg_relu = 1'b0; cfg_skip = 1'b0;
    bus.param_valid = 1'b0; bus.pix_valid = 1'b0;
    exp_relu = 1'b0; exp_skip = 1'b0; exp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    reset = 1'b1;
    step();
    chk_idle("post_reset");

    start = 1'b1; abort = 1'b1; cfg_relu = 1'b1; cfg_skip = 1'b1;
    #1;
    chk_idle("abort_start");
    step();
    start = 1'b0; abort = 1'b0;
    #1;
    chk_idle("abort_start_next");
    step();

    run_layer(1'b0, 1'b1, 0, 0, 0);
    run_layer(1'b0, 1'b0, 2, 1, 0);
    run_layer(1'b1, 1'b1, 0, 0, 0);
    run_layer(1'b0, 1'b1, 1, 0, 1);
    run_layer(1'b0, 1'b0, 0, 0, 0);
    run_layer(1'b0, 1'b1, 0, 0, 3);
    run_layer(1'b0, 1'b1, 0, 1, 0);
    run_layer(1'b1, 1'b0, 1, 1, 0);
    run_layer(1'b0, 1'b1, 1, 1, 2);
    run_layer(1'b1, 1'b1, 0, 0, 2);
    for (int i = 0; i < 6; i++)
      run_layer(1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
